led_pwm_ctrl: RTL and testbench

//  Parametrised N-channel LED PWM engine with an 8-bit register file, driven by the I2C controller's register strobes.
//  Per-channel 8-bit duty, per-channel output mode, group dimming or group blinking, and a sleep mode.

---
 rtl/led_pwm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
// N-channel LED PWM engine: 8-bit register file, per-channel duty/mode, group dim or blink, sleep.
// Duty and group level are double-buffered and switch only at the 255 -> 0 PWM wrap.
module led_pwm_ctrl #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter bit          OUT_INV = 1'b0
) (
    input  logic              clk_osc,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        reg_wdata,
    input  logic              reg_write,
    input  logic              reg_read,
    output logic [7:0]        reg_rdata,
    output logic              sleep,
    output logic [N_CH-1:0]   leds
);
    localparam int unsigned NL          = (N_CH + 3) / 4;
    localparam int unsigned LED_W       = 8 * NL;
    localparam int unsigned LEDOUT_BASE = 3;
    localparam int unsigned PWM_BASE    = LEDOUT_BASE + NL;
    // Only fields of existing channels are writable; the rest stay 0.
    localparam logic [LED_W-1:0] LED_MASK = LED_W'((64'd1 << (2 * N_CH)) - 64'd1);

    logic [31:0] addr;
    assign addr = 32'(reg_addr);

    logic                  dmblnk_q, dmblnk_d;
    logic                  sleep_q, sleep_d;
    logic [7:0]            grppwm_sh_q, grppwm_sh_d;
    logic [7:0]            grppwm_act_q, grppwm_act_d;
    logic [7:0]            grpfreq_q, grpfreq_d;
    logic [LED_W-1:0]      ledout_q, ledout_d;
    logic [N_CH-1:0][7:0]  pwm_sh_q, pwm_sh_d;
    logic [N_CH-1:0][7:0]  pwm_act_q, pwm_act_d;
    logic [7:0]            pwm_cnt_q, pwm_cnt_d;
    logic [7:0]            grp_cnt_q, grp_cnt_d;
    logic [7:0]            bdiv_q, bdiv_d;
    logic [7:0]            bpos_q, bpos_d;
    logic [N_CH-1:0]       leds_q, leds_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [7:0]            rd_val;
    logic [N_CH-1:0]       raw;
    logic                  gate;

    // Register writes (shadow side)
    always_comb begin
        dmblnk_d    = dmblnk_q;
        sleep_d     = sleep_q;
        grppwm_sh_d = grppwm_sh_q;
        grpfreq_d   = grpfreq_q;
        ledout_d    = ledout_q;
        pwm_sh_d    = pwm_sh_q;
        if (reg_write) begin
            if (addr == 32'd0) begin
                dmblnk_d = reg_wdata[5];
                sleep_d  = reg_wdata[4];
            end
            if (addr == 32'd1) grppwm_sh_d = reg_wdata;
            if (addr == 32'd2) grpfreq_d = reg_wdata;
            for (int unsigned k = 0; k < NL; k++) begin
                if (addr == LEDOUT_BASE + k) ledout_d[8*k +: 8] = reg_wdata & LED_MASK[8*k +: 8];
            end
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (addr == PWM_BASE + i) pwm_sh_d[i] = reg_wdata;
            end
        end
    end

    // Read mux over pre-edge state, so a same-cycle write is not visible
    always_comb begin
        rd_val = 8'h00;
        if (addr == 32'd0) rd_val = {2'b00, dmblnk_q, sleep_q, 4'b0000};
        if (addr == 32'd1) rd_val = grppwm_sh_q;
        if (addr == 32'd2) rd_val = grpfreq_q;
        for (int unsigned k = 0; k < NL; k++) begin
            if (addr == LEDOUT_BASE + k) rd_val = ledout_q[8*k +: 8];
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (addr == PWM_BASE + i) rd_val = pwm_sh_q[i];
        end
        rdata_d = reg_read ? rd_val : rdata_q;
    end

    // Counters and shadow-to-active transfer
    always_comb begin
        pwm_cnt_d    = pwm_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        bdiv_d       = bdiv_q;
        bpos_d       = bpos_q;
        pwm_act_d    = pwm_act_q;
        grppwm_act_d = grppwm_act_q;
        if (sleep_q) begin
            pwm_cnt_d = 8'd0;
            grp_cnt_d = 8'd0;
            bdiv_d    = 8'd0;
            bpos_d    = 8'd0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                grp_cnt_d    = grp_cnt_q + 8'd1;
                pwm_act_d    = pwm_sh_q;
                grppwm_act_d = grppwm_sh_q;
                // >= keeps the divider from running away if GRPFREQ drops below bdiv
                if (bdiv_q >= grpfreq_q) begin
                    bdiv_d = 8'd0;
                    bpos_d = bpos_q + 8'd1;
                end else begin
                    bdiv_d = bdiv_q + 8'd1;
                end
            end
        end
    end

    // Per-channel output selection
    always_comb begin
        raw  = '0;
        gate = dmblnk_q ? (bpos_q < grppwm_act_q) : (grp_cnt_q < grppwm_act_q);
        for (int unsigned i = 0; i < N_CH; i++) begin
            case (ledout_q[2*i +: 2])
                2'b00:   raw[i] = 1'b0;
                2'b01:   raw[i] = 1'b1;
                2'b10:   raw[i] = (pwm_cnt_q < pwm_act_q[i]);
                default: raw[i] = (pwm_cnt_q < pwm_act_q[i]) & gate;
            endcase
        end
        leds_d = sleep_q ? '0 : raw;
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            dmblnk_q     <= 1'b0;
            sleep_q      <= 1'b1;
            grppwm_sh_q  <= 8'hFF;
            grppwm_act_q <= 8'hFF;
            grpfreq_q    <= 8'h00;
            ledout_q     <= '0;
            pwm_sh_q     <= '0;
            pwm_act_q    <= '0;
            pwm_cnt_q    <= 8'd0;
            grp_cnt_q    <= 8'd0;
            bdiv_q       <= 8'd0;
            bpos_q       <= 8'd0;
            leds_q       <= '0;
            rdata_q      <= 8'h00;
        end else begin
            dmblnk_q     <= dmblnk_d;
            sleep_q      <= sleep_d;
            grppwm_sh_q  <= grppwm_sh_d;
            grppwm_act_q <= grppwm_act_d;
            grpfreq_q    <= grpfreq_d;
            ledout_q     <= ledout_d;
            pwm_sh_q     <= pwm_sh_d;
            pwm_act_q    <= pwm_act_d;
            pwm_cnt_q    <= pwm_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            bdiv_q       <= bdiv_d;
            bpos_q       <= bpos_d;
            leds_q       <= leds_d;
            rdata_q      <= rdata_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign sleep     = sleep_q;
    assign leds      = leds_q ^ {N_CH{OUT_INV}};

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl (N_CH=4): directed scenarios plus random register traffic,
// checked every cycle against a time-based model of the PWM engine.
module tb_led_pwm_ctrl;
    logic       clk_osc = 1'b0;
    logic       reset;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;
    logic       sleep;
    logic [3:0] leds;

    always #5 clk_osc = ~clk_osc;

    led_pwm_ctrl #(
        .N_CH   (4),
        .ADDR_W (3),
        .OUT_INV(1'b0)
    ) dut (
        .clk_osc  (clk_osc),
        .reset    (reset),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_write(reg_write),
        .reg_read (reg_read),
        .reg_rdata(reg_rdata),
        .sleep    (sleep),
        .leds     (leds)
    );

    // Model: m_cnt = clock edges elapsed since the engine last woke up.
    logic       m_dm, m_sleep;
    logic [7:0] m_grppwm, m_grppwm_act, m_grpfreq, m_ledout;
    logic [7:0] m_pwm [4];
    logic [7:0] m_pwm_act [4];
    int         m_cnt;
    logic [3:0] exp_leds;
    logic [7:0] exp_rdata;
    int         hi_cnt [4];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {2'b00, m_dm, m_sleep, 4'b0000};
            3'd1:    return m_grppwm;
            3'd2:    return m_grpfreq;
            3'd3:    return m_ledout;
            default: return m_pwm[int'(a) - 4];
        endcase
    endfunction

    task automatic model_step(input logic [2:0] a, input logic [7:0] d, input logic w,
                              input logic r, input logic rs);
        int         pc, per, grp, bp;
        logic       gate;
        logic [3:0] nl;
        if (rs) begin
            m_dm = 1'b0; m_sleep = 1'b1; m_grppwm = 8'hFF; m_grppwm_act = 8'hFF;
            m_grpfreq = 8'h00; m_ledout = 8'h00; m_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                m_pwm[c] = 8'h00;
                m_pwm_act[c] = 8'h00;
            end
            exp_leds = 4'h0; exp_rdata = 8'h00;
            return;
        end
        pc   = m_cnt % 256;
        per  = m_cnt / 256;
        grp  = per % 256;
        bp   = (per / (int'(m_grpfreq) + 1)) % 256;
        gate = m_dm ? (bp < int'(m_grppwm_act)) : (grp < int'(m_grppwm_act));
        nl   = 4'h0;
        for (int c = 0; c < 4; c++) begin
            case (m_ledout[2*c +: 2])
                2'b00:   nl[c] = 1'b0;
                2'b01:   nl[c] = 1'b1;
                2'b10:   nl[c] = (pc < int'(m_pwm_act[c]));
                default: nl[c] = (pc < int'(m_pwm_act[c])) && gate;
            endcase
        end
        exp_leds = m_sleep ? 4'h0 : nl;
        if (r) exp_rdata = model_read(a);
        if (m_sleep) m_cnt = 0;
        else begin
            if (pc == 255) begin
                for (int c = 0; c < 4; c++) m_pwm_act[c] = m_pwm[c];
                m_grppwm_act = m_grppwm;
            end
            m_cnt++;
        end
        if (w) begin
            case (a)
                3'd0:    begin m_dm = d[5]; m_sleep = d[4]; end
                3'd1:    m_grppwm = d;
                3'd2:    m_grpfreq = d;
                3'd3:    m_ledout = d;
                default: m_pwm[int'(a) - 4] = d;
            endcase
        end
    endtask

    // One clock: drive, take the edge, advance the model, compare every output.
    task automatic cyc(input logic [2:0] a, input logic [7:0] d, input logic w,
                       input logic r, input logic rs);
        reg_addr = a; reg_wdata = d; reg_write = w; reg_read = r; reset = rs;
        @(posedge clk_osc);
        #1;
        model_step(a, d, w, r, rs);
        check("leds", {4'h0, leds}, {4'h0, exp_leds});
        check("rdata", reg_rdata, exp_rdata);
        check("sleep", {7'h0, sleep}, {7'h0, m_sleep});
        for (int c = 0; c < 4; c++) hi_cnt[c] += int'(leds[c]);
        reg_write = 1'b0; reg_read = 1'b0; reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cyc(a, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(a, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    // Advance until the next edge samples pwm_cnt = 0 of a period after the wake-up one
    task automatic align();
        int k;
        k = 0;
        while (!((m_cnt % 256) == 0 && m_cnt > 0) && k < 600) begin
            idle(1);
            k++;
        end
        check_int("align_budget", (k < 600) ? 1 : 0, 1);
    endtask

    task automatic count_period();
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        idle(256);
    endtask

    initial begin
        reg_addr = 3'd0; reg_wdata = 8'h00; reg_write = 1'b0; reg_read = 1'b0; reset = 1'b1;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;

        // Reset state
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_leds", {4'h0, leds}, 8'h00);
        check("rst_rdata", reg_rdata, 8'h00);
        check("rst_sleep", {7'h0, sleep}, 8'h01);
        rd(3'd0); check("rst_mode", reg_rdata, 8'h10);
        rd(3'd1); check("rst_grppwm", reg_rdata, 8'hFF);
        rd(3'd4); check("rst_pwm0", reg_rdata, 8'h00);
        rd(3'd7); check("rst_pwm3", reg_rdata, 8'h00);
        idle(2);  check("rdata_hold", reg_rdata, 8'h00);

        // Plain PWM duties
        wr(3'd3, 8'hAA);
        wr(3'd4, 8'h40); wr(3'd5, 8'h00); wr(3'd6, 8'hFF); wr(3'd7, 8'h80);
        wr(3'd0, 8'h00);
        align();
        count_period();
        check_int("duty_40", hi_cnt[0], 64);
        check_int("duty_00", hi_cnt[1], 0);
        check_int("duty_FF", hi_cnt[2], 255);
        check_int("duty_80", hi_cnt[3], 128);

        // Mid-period duty change lands at the next period
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        idle(100);
        wr(3'd4, 8'hC0);
        idle(155);
        check_int("shadow_cur", hi_cnt[0], 64);
        count_period();
        check_int("shadow_next", hi_cnt[0], 192);
        rd(3'd4); check("shadow_read", reg_rdata, 8'hC0);

        // Group dimming: GRPPWM=2 -> periods 0,1 only
        wr(3'd0, 8'h10);
        wr(3'd3, 8'hFF);
        for (int c = 0; c < 4; c++) wr(3'(4 + c), 8'h80);
        wr(3'd1, 8'h02);
        wr(3'd0, 8'h00);
        align();
        count_period();
        check_int("dim_p1", hi_cnt[0], 128);
        count_period();
        check_int("dim_p2", hi_cnt[3], 0);

        // Group blinking: GRPFREQ=1 -> bpos = period/2, on while bpos < 2
        wr(3'd0, 8'h10);
        wr(3'd2, 8'h01);
        for (int c = 0; c < 4; c++) wr(3'(4 + c), 8'hFF);
        wr(3'd0, 8'h20);
        align();
        count_period();
        check_int("blink_p1", hi_cnt[2], 255);
        count_period();
        count_period();
        check_int("blink_p3", hi_cnt[2], 255);
        count_period();
        check_int("blink_p4", hi_cnt[2], 0);

        // Sleep entry/exit with all channels forced on
        wr(3'd3, 8'h55);
        idle(3);
        check("on_awake", {4'h0, leds}, 8'h0F);
        wr(3'd0, 8'h10);
        check("sleep_wr_edge", {4'h0, leds}, 8'h0F);
        idle(1);
        check("sleep_off", {4'h0, leds}, 8'h00);
        idle(5);
        wr(3'd0, 8'h00);
        check("wake_wr_edge", {4'h0, leds}, 8'h00);
        idle(1);
        check("wake_on", {4'h0, leds}, 8'h0F);
        rd(3'd3); check("ledout_read", reg_rdata, 8'h55);

        // Random register traffic
        for (int i = 0; i < 20000; i++) begin
            int         r;
            logic [2:0] a;
            logic [7:0] d;
            logic       w, rdv, rs;
            r = int'($urandom_range(0, 99));
            d = 8'($urandom);
            w = 1'b1;
            if (r < 2) begin
                a = 3'd0;
                d[4] = ($urandom_range(0, 3) == 0);
            end else if (r < 5) begin
                a = 3'd2;
                d = 8'($urandom_range(0, 3));
                w = m_sleep;
            end else if (r < 9) begin
                a = 3'd1;
            end else if (r < 16) begin
                a = 3'd3;
            end else if (r < 30) begin
                a = 3'(4 + $urandom_range(0, 3));
            end else begin
                a = 3'($urandom_range(0, 7));
                w = 1'b0;
            end
            rdv = ($urandom_range(0, 2) == 0);
            rs  = ($urandom_range(0, 2999) == 0);
            cyc(a, d, w, rdv, rs);
        end

        // Reset from an arbitrary point
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("final_rst_leds", {4'h0, leds}, 8'h00);
        rd(3'd1); check("final_rst_grppwm", reg_rdata, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
